// File: rtl/subleq_control.sv
// SUBLEQ sequencer: fetches A/B/C, reads mem[A]/mem[B], drives the external ALU, writes back, branches.
// Optional self-branch halt detection enabled by defining SUBLEQ_HALT_EN.
module subleq_control #(
    parameter int unsigned   DW       = 16,
    parameter logic [DW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run,
    output logic          mem_req,
    output logic          mem_we,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic [DW-1:0] r_q,
    output logic [DW-1:0] bus_q,
    output logic          comp,
    input  logic [DW-1:0] alu_result,
    input  logic          flag_n,
    input  logic          flag_z,
    output logic [DW-1:0] pc,
    output logic          busy,
    output logic          halted
);

`ifdef SUBLEQ_HALT_EN
    localparam bit HaltEn = 1'b1;
`else
    localparam bit HaltEn = 1'b0;
`endif

    typedef enum logic [2:0] {
        StIdle, StFetchA, StFetchB, StFetchC, StReadA, StReadB, StExec, StWrite
    } state_e;

    state_e        state_q, state_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [DW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] pc_q, pc_d;
    logic [DW-1:0] opa_q, opa_d;
    logic [DW-1:0] opb_q, opb_d;
    logic [DW-1:0] opc_q, opc_d;
    logic [DW-1:0] r_d, bus_d;
    logic          take_q, take_d;
    logic          halted_q, halted_d;
    logic          is_mem;
    logic          ack;
    logic [DW-1:0] issue_addr;

    assign is_mem = (state_q != StIdle) && (state_q != StExec);
    assign ack    = req_q & mem_ack;

    always_comb begin
        issue_addr = '0;
        case (state_q)
            StFetchA:         issue_addr = pc_q;
            StFetchB:         issue_addr = pc_q + DW'(1);
            StFetchC:         issue_addr = pc_q + DW'(2);
            StReadA:          issue_addr = opa_q;
            StReadB, StWrite: issue_addr = opb_q;
            default:          issue_addr = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        pc_d     = pc_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        opc_d    = opc_q;
        r_d      = r_q;
        bus_d    = bus_q;
        take_d   = take_q;
        halted_d = halted_q;

        // Request is issued one cycle after state entry and dropped on ack,
        // guaranteeing a low cycle between consecutive transactions.
        if (is_mem) begin
            if (!req_q) begin
                req_d  = 1'b1;
                addr_d = issue_addr;
                we_d   = (state_q == StWrite);
            end else if (mem_ack) begin
                req_d = 1'b0;
                we_d  = 1'b0;
            end
        end

        case (state_q)
            StIdle:   if (run && !halted_q) state_d = StFetchA;
            StFetchA: if (ack) begin opa_d = mem_rdata; state_d = StFetchB; end
            StFetchB: if (ack) begin opb_d = mem_rdata; state_d = StFetchC; end
            StFetchC: if (ack) begin opc_d = mem_rdata; state_d = StReadA; end
            StReadA:  if (ack) begin r_d   = mem_rdata; state_d = StReadB; end
            StReadB:  if (ack) begin bus_d = mem_rdata; state_d = StExec;  end
            StExec: begin
                wdata_d = alu_result;
                take_d  = flag_n | flag_z;
                state_d = StWrite;
            end
            StWrite: begin
                if (ack) begin
                    if (HaltEn && take_q && (opc_q == pc_q)) begin
                        halted_d = 1'b1;
                        state_d  = StIdle;
                    end else begin
                        pc_d    = take_q ? opc_q : pc_q + DW'(3);
                        state_d = run ? StFetchA : StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            pc_q     <= RESET_PC;
            opa_q    <= '0;
            opb_q    <= '0;
            opc_q    <= '0;
            r_q      <= '0;
            bus_q    <= '0;
            take_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            pc_q     <= pc_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            opc_q    <= opc_d;
            r_q      <= r_d;
            bus_q    <= bus_d;
            take_q   <= take_d;
            halted_q <= halted_d;
        end
    end

    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign pc        = pc_q;
    assign comp      = (state_q == StExec);
    assign busy      = (state_q != StIdle);
    assign halted    = HaltEn & halted_q;

endmodule
